sata_axi_regs: RTL and testbench

AXI3 slave register file on the PS general-purpose master port (GP1) of the SATA host, 32-bit data. It accepts single-beat and burst reads and writes from the PS, stores words in an internal register array with byte-lane masking, and echoes transaction IDs. Every completed write beat also produces a one-cycle strobe toward the SATA control logic.

---
 rtl/sata_axi_regs.sv | 195 +++++++++++++++++++
 tb/tb_sata_axi_regs.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sata_axi_regs.sv
// AXI3 slave register file for the SATA host GP1 port: 2^REG_ADDR_BITS x 32-bit words,
// byte-lane writes, FIXED/INCR bursts, and a write strobe toward the SATA control logic.
module sata_axi_regs #(
    parameter int REG_ADDR_BITS = 4
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic [31:0]              AWADDR,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [11:0]              AWID,
    input  logic [3:0]               AWLEN,
    input  logic [1:0]               AWSIZE,
    input  logic [1:0]               AWBURST,
    input  logic [31:0]              WDATA,
    input  logic [3:0]               WSTRB,
    input  logic                     WVALID,
    output logic                     WREADY,
    input  logic [11:0]              WID,
    input  logic                     WLAST,
    output logic                     BVALID,
    input  logic                     BREADY,
    output logic [11:0]              BID,
    output logic [1:0]               BRESP,
    input  logic [31:0]              ARADDR,
    input  logic [11:0]              ARID,
    input  logic [3:0]               ARLEN,
    input  logic [1:0]               ARSIZE,
    input  logic [1:0]               ARBURST,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    output logic [31:0]              RDATA,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic [11:0]              RID,
    output logic                     RLAST,
    output logic [1:0]               RRESP,
    output logic                     reg_wr_stb,
    output logic [REG_ADDR_BITS-1:0] reg_wr_addr,
    output logic [31:0]              reg_wr_data,
    output logic [1:0]               wr_state_dbg,
    output logic                     rd_state_dbg
);
    localparam int NREGS = 1 << REG_ADDR_BITS;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;
    typedef logic [REG_ADDR_BITS-1:0] idx_t;

    logic [31:0] regs [NREGS];
    logic        rst_done;
    wr_state_t   wr_state, wr_next;
    rd_state_t   rd_state, rd_next;
    idx_t        wr_idx, rd_idx, rd_next_idx;
    logic [3:0]  wr_cnt, rd_cnt;
    logic        wr_fixed, rd_fixed, wr_err;
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, w_final;
    logic [31:0] w_merged;
    logic        unused_ok;

    assign unused_ok = &{1'b0, AWSIZE, ARSIZE, WID, AWADDR[31:REG_ADDR_BITS+2], AWADDR[1:0],
                         ARADDR[31:REG_ADDR_BITS+2], ARADDR[1:0]};

    // Every channel transfers on a rising edge where its VALID and READY are both high;
    // a source holds VALID and payload stable until that edge.
    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign b_hs  = BVALID && BREADY;
    assign ar_hs = ARVALID && ARREADY;
    assign r_hs  = RVALID && RREADY;

    assign wr_state_dbg = wr_state;
    assign rd_state_dbg = rd_state;
    assign RRESP        = 2'b00;

    // Keeps both address channels closed until the first edge with reset released.
    always_ff @(posedge ACLK) begin
        rst_done <= ARESETN;
    end

    // ---------------- write FSM ----------------
    always_ff @(posedge ACLK) begin
        if (!ARESETN) wr_state <= W_IDLE;
        else          wr_state <= wr_next;
    end

    assign w_final = (wr_cnt == 4'd0) || WLAST;

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE:  if (aw_hs) wr_next = W_DATA;
            W_DATA:  if (w_hs && w_final) wr_next = W_RESP;
            W_RESP:  if (b_hs) wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        AWREADY = rst_done && (wr_state == W_IDLE);
        WREADY  = (wr_state == W_DATA);
        BVALID  = (wr_state == W_RESP);
        BRESP   = (BVALID && wr_err) ? 2'b10 : 2'b00;
    end

    always_comb begin
        w_merged = regs[wr_idx];
        for (int i = 0; i < 4; i++) begin
            if (WSTRB[i]) w_merged[8*i +: 8] = WDATA[8*i +: 8];
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_idx      <= '0;
            wr_cnt      <= '0;
            wr_fixed    <= 1'b0;
            wr_err      <= 1'b0;
            BID         <= '0;
            reg_wr_stb  <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            reg_wr_stb <= 1'b0;
            if (aw_hs) begin
                wr_idx   <= AWADDR[REG_ADDR_BITS+1:2];
                wr_cnt   <= AWLEN;
                wr_fixed <= (AWBURST == 2'b00);
                BID      <= AWID;
            end
            if (w_hs) begin
                regs[wr_idx] <= w_merged;
                reg_wr_stb   <= 1'b1;
                reg_wr_addr  <= wr_idx;
                reg_wr_data  <= w_merged;
                wr_cnt       <= wr_cnt - 1'b1;
                if (!wr_fixed) wr_idx <= wr_idx + 1'b1;
                // WLAST must coincide exactly with the counted final beat
                if (WLAST != (wr_cnt == 4'd0)) wr_err <= 1'b1;
            end
            if (b_hs) wr_err <= 1'b0;
        end
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge ACLK) begin
        if (!ARESETN) rd_state <= R_IDLE;
        else          rd_state <= rd_next;
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs) rd_next = R_DATA;
            R_DATA:  if (r_hs && (rd_cnt == 4'd0)) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        ARREADY = rst_done && (rd_state == R_IDLE);
        RVALID  = (rd_state == R_DATA);
    end

    assign rd_next_idx = rd_fixed ? rd_idx : rd_idx + 1'b1;

    // RDATA samples the array before any same-edge write lands, so a collision returns the old word.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            rd_idx   <= '0;
            rd_cnt   <= '0;
            rd_fixed <= 1'b0;
            RID      <= '0;
            RDATA    <= '0;
            RLAST    <= 1'b0;
        end else if (ar_hs) begin
            rd_idx   <= ARADDR[REG_ADDR_BITS+1:2];
            rd_cnt   <= ARLEN;
            rd_fixed <= (ARBURST == 2'b00);
            RID      <= ARID;
            RDATA    <= regs[ARADDR[REG_ADDR_BITS+1:2]];
            RLAST    <= (ARLEN == 4'd0);
        end else if (r_hs) begin
            if (rd_cnt == 4'd0) begin
                RLAST <= 1'b0;
            end else begin
                rd_idx <= rd_next_idx;
                rd_cnt <= rd_cnt - 1'b1;
                RDATA  <= regs[rd_next_idx];
                RLAST  <= (rd_cnt == 4'd1);
            end
        end
    end
endmodule

// File: tb/tb_sata_axi_regs.sv
// Bench for sata_axi_regs: a word model predicts read data and write strobes, which are
// queued when stimulus is driven and compared as the DUT produces them.
module tb_sata_axi_regs;
    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0;
    logic        AWVALID = 1'b0, WVALID = 1'b0, WLAST = 1'b0, BREADY = 1'b0;
    logic        ARVALID = 1'b0, RREADY = 1'b0;
    logic [11:0] AWID = '0, WID = '0, ARID = '0;
    logic [3:0]  AWLEN = '0, ARLEN = '0, WSTRB = '0;
    logic [1:0]  AWSIZE = 2'b10, AWBURST = '0, ARSIZE = 2'b10, ARBURST = '0;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, reg_wr_stb, rd_state_dbg;
    logic [11:0] BID, RID;
    logic [1:0]  BRESP, RRESP, wr_state_dbg;
    logic [31:0] RDATA, reg_wr_data;
    logic [3:0]  reg_wr_addr;

    sata_axi_regs #(.REG_ADDR_BITS(4)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWLEN(AWLEN),
        .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY), .WID(WID), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
        .ARADDR(ARADDR), .ARID(ARID), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .RID(RID), .RLAST(RLAST), .RRESP(RRESP),
        .reg_wr_stb(reg_wr_stb), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .wr_state_dbg(wr_state_dbg), .rd_state_dbg(rd_state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model [16];
    logic [32:0] exp_q [$];   // {rlast, rdata}
    logic [35:0] stb_q [$];   // {addr, data}
    logic [3:0]  m_idx;
    logic        m_fixed;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge ACLK) begin
        if (RVALID && RREADY) begin
            if (exp_q.size() == 0) check("rd_q_empty", exp_q.size(), 1);
            else                   check("rdata", {RLAST, RDATA}, exp_q.pop_front());
        end
        if (reg_wr_stb) begin
            if (stb_q.size() == 0) check("stb_q_empty", stb_q.size(), 1);
            else                   check("wr_stb", {reg_wr_addr, reg_wr_data}, stb_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_aw(input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input logic [11:0] id);
        int w;
        w = 0;
        AWVALID = 1'b1; AWADDR = addr; AWLEN = len; AWBURST = burst; AWID = id;
        @(negedge ACLK);
        while (!AWREADY && w < 50) begin w++; @(negedge ACLK); end
        check("awready", AWREADY, 1);
        m_idx   = addr[5:2];
        m_fixed = (burst == 2'b00);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
    endtask

    task automatic drive_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int w;
        logic [31:0] merged;
        w = 0;
        WVALID = 1'b1; WDATA = data; WSTRB = strb; WLAST = last;
        @(negedge ACLK);
        while (!WREADY && w < 50) begin w++; @(negedge ACLK); end
        check("wready_wait", w, 0);
        if (WREADY) begin
            merged = model[m_idx];
            for (int b = 0; b < 4; b++) if (strb[b]) merged[8*b +: 8] = data[8*b +: 8];
            model[m_idx] = merged;
            stb_q.push_back({m_idx, merged});
            if (!m_fixed) m_idx++;
        end
        @(posedge ACLK); #1;
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                             input logic [11:0] id, input int last_at, input logic [3:0] strb,
                             input logic [31:0] base);
        int nb, w;
        logic exp_err;
        w = 0;
        send_aw(addr, len, burst, id);
        nb = (last_at < int'(len)) ? last_at + 1 : int'(len) + 1;
        exp_err = (last_at != int'(len));
        for (int i = 0; i < nb; i++) drive_beat(base + i, strb, i == last_at);
        BREADY = 1'b1;
        @(negedge ACLK);
        while (!BVALID && w < 50) begin w++; @(negedge ACLK); end
        check("b_latency", w, 0);
        check("bresp", BRESP, exp_err ? 2'b10 : 2'b00);
        check("bid", BID, id);
        @(posedge ACLK); #1;
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                            input logic [11:0] id, input bit toggle, input int exp_cycles);
        int w, taken, cyc;
        logic [3:0] idx;
        logic [32:0] prev;
        logic stalled;
        w = 0; taken = 0; cyc = 0; stalled = 1'b0; prev = '0;
        ARVALID = 1'b1; ARADDR = addr; ARLEN = len; ARBURST = burst; ARID = id;
        @(negedge ACLK);
        while (!ARREADY && w < 50) begin w++; @(negedge ACLK); end
        check("arready", ARREADY, 1);
        idx = addr[5:2];
        for (int i = 0; i <= int'(len); i++) begin
            exp_q.push_back({i == int'(len), model[idx]});
            if (burst != 2'b00) idx++;
        end
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        while (taken <= int'(len) && cyc < 100) begin
            RREADY = toggle ? (cyc % 2 == 1) : 1'b1;
            @(negedge ACLK);
            if (cyc == 0) check("rvalid_first", RVALID, 1);
            if (stalled) check("r_hold", {RLAST, RDATA}, prev);
            if (RVALID) check("rid", RID, id);
            stalled = RVALID && !RREADY;
            prev = {RLAST, RDATA};
            if (RVALID && RREADY) taken++;
            @(posedge ACLK); #1;
            cyc++;
        end
        RREADY = 1'b0;
        check("r_cycles", cyc, exp_cycles);
    endtask

    task automatic release_reset();
        ARESETN = 1'b1;
        @(negedge ACLK);
        check("awready_pre", AWREADY, 0);
        @(negedge ACLK);
        check("ready_post", {AWREADY, ARREADY}, 2'b11);
        @(posedge ACLK); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a, base;
        logic [3:0]  len;
        logic [1:0]  burst;
        for (int i = 0; i < 16; i++) model[i] = '0;

        repeat (3) @(posedge ACLK);
        #1;
        check("rst_ctl", {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, BRESP, RRESP, reg_wr_stb}, 0);
        check("rst_ids", {BID, RID, reg_wr_addr}, 0);
        check("rst_rdata", RDATA, 0);
        check("rst_wdata", reg_wr_data, 0);
        release_reset();

        // single beat with partial strobe, then read back
        axi_write(32'h5, 4'd0, 2'b01, 12'h123, 0, 4'b1011, 32'hdeadbeef);
        axi_read(32'h5, 4'd0, 2'b01, 12'h456, 1'b0, 1);

        // INCR burst wrapping past the top word
        axi_write(32'h38, 4'd3, 2'b01, 12'h007, 3, 4'hf, 32'd1);
        axi_read(32'h38, 4'd3, 2'b01, 12'h008, 1'b0, 4);

        // FIXED burst on word 3
        axi_write(32'hc, 4'd2, 2'b00, 12'h00a, 2, 4'hf, 32'ha);
        axi_read(32'hc, 4'd0, 2'b01, 12'h00b, 1'b0, 1);

        // early WLAST, then a clean write
        axi_write(32'h20, 4'd3, 2'b01, 12'hbad, 1, 4'hf, 32'h100);
        axi_write(32'h2c, 4'd0, 2'b01, 12'h0c0, 0, 4'hf, 32'h55aa55aa);
        axi_read(32'h20, 4'd3, 2'b01, 12'h0c1, 1'b0, 4);

        // read with RREADY toggling
        axi_read(32'h38, 4'd3, 2'b01, 12'h0d0, 1'b1, 8);

        // random traffic, aliased upper address bits included
        repeat (6) begin
            a     = {$urandom_range(0, 255), $urandom_range(0, 15), 2'b00};
            len   = 4'($urandom_range(0, 7));
            burst = 2'($urandom_range(0, 3));
            base  = $urandom;
            axi_write(a, len, burst, 12'($urandom_range(0, 4095)), int'(len),
                      4'($urandom_range(0, 15)), base);
            axi_read(a, len, burst, 12'($urandom_range(0, 4095)), 1'b0, int'(len) + 1);
        end

        // reset during the second beat of a 4-beat write
        send_aw(32'h10, 4'd3, 2'b01, 12'h0e0);
        drive_beat(32'h66, 4'hf, 1'b0);
        WVALID = 1'b1; WDATA = 32'h77; WSTRB = 4'hf; ARESETN = 1'b0;
        @(posedge ACLK); #1;
        check("abort_ctl", {AWREADY, WREADY, BVALID, ARREADY, RVALID}, 0);
        check("abort_stb", reg_wr_stb, 0);
        check("abort_wr_state", wr_state_dbg, 0);
        WVALID = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        @(posedge ACLK); #1;
        release_reset();
        axi_read(32'h0, 4'd15, 2'b01, 12'h0f0, 1'b0, 16);
        axi_write(32'h18, 4'd0, 2'b01, 12'h0f1, 0, 4'hf, 32'hcafef00d);
        axi_read(32'h18, 4'd0, 2'b01, 12'h0f2, 1'b0, 1);

        repeat (2) @(posedge ACLK);
        check("exp_q_left", exp_q.size(), 0);
        check("stb_q_left", stb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
